// File: rtl/fifo_unpacker.sv
// Wide-to-narrow FIFO adapter: pops one OUT_WIDTH*RATIO word from an FWFT FIFO
// and writes it out as RATIO chunks, refilling in the same cycle as the last chunk.
module fifo_unpacker #(
    parameter int OUT_WIDTH = 8,
    parameter int RATIO     = 4,
    parameter bit MSB_FIRST = 1'b0,
    localparam int IN_WIDTH = OUT_WIDTH * RATIO,
    localparam int CW       = $clog2(RATIO + 1)
) (
    input  logic                 CLK,
    input  logic                 rst,
    input  logic [IN_WIDTH-1:0]  in_dout,
    input  logic                 in_empty,
    output logic                 in_rd_en,
    output logic [OUT_WIDTH-1:0] out_din,
    output logic                 out_wr_en,
    input  logic                 out_full,
    output logic                 idle,
    output logic [CW-1:0]        chunks_left
);

    typedef enum logic {EMPTY, SHIFT} state_t;

    logic [IN_WIDTH-1:0] r_hold;
    logic [CW-1:0]       r_cnt;
    state_t              w_state;
    logic                w_wr;
    logic                w_rd;
    logic                w_last;

    always_comb begin
        w_state = EMPTY;
        w_wr    = 1'b0;
        w_rd    = 1'b0;
        w_last  = (r_cnt == CW'(1));
        if (r_cnt != '0)
            w_state = SHIFT;
        case (w_state)
            EMPTY: w_rd = ~rst & ~in_empty;
            SHIFT: begin
                w_wr = ~rst & ~out_full;
                // Refill on the last chunk's write so the stream has no bubble.
                w_rd = ~rst & ~in_empty & w_last & w_wr;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (rst)
            r_cnt <= '0;
        else if (w_rd)
            r_cnt <= CW'(RATIO);
        else if (w_wr)
            r_cnt <= r_cnt - CW'(1);
    end

    // Holding register needs no reset: it is only observed while r_cnt != 0.
    always_ff @(posedge CLK) begin
        if (w_rd)
            r_hold <= in_dout;
        else if (w_wr) begin
            if (MSB_FIRST)
                r_hold <= r_hold << OUT_WIDTH;
            else
                r_hold <= r_hold >> OUT_WIDTH;
        end
    end

    assign in_rd_en    = w_rd;
    assign out_wr_en   = w_wr;
    assign out_din     = MSB_FIRST ? r_hold[IN_WIDTH-1 -: OUT_WIDTH] : r_hold[OUT_WIDTH-1:0];
    assign idle        = (r_cnt == '0);
    assign chunks_left = r_cnt;

endmodule

// File: doc/fifo_unpacker.md
Name: fifo_unpacker

Overview:
- Reader-side companion to the team's synchronous FWFT FIFOs.
- Drains wide words from an upstream FWFT FIFO read port (dout/empty/rd_en) and emits them as RATIO narrow chunks into a downstream FIFO write port (din/wr_en/full).
- Used wherever a wide internal datapath must feed a narrower output stream, e.g. result words heading to the host interface.
- Zero-bubble: sustains one chunk per cycle across word boundaries.

Parameters:
- OUT_WIDTH, 8, width of one output chunk (bits).
- RATIO, 4, chunks per input word; input width is OUT_WIDTH*RATIO; RATIO >= 2.
- MSB_FIRST, 0, 0: emit least-significant chunk first; 1: emit most-significant chunk first.

Ports:
- CLK  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- in_dout  in  OUT_WIDTH*RATIO  upstream FWFT data, valid when in_empty=0.
- in_empty  in  1  upstream FIFO empty.
- in_rd_en  out  1  upstream read strobe (pop).
- out_din  out  OUT_WIDTH  chunk to downstream FIFO.
- out_wr_en  out  1  downstream write strobe.
- out_full  in  1  downstream FIFO full.
- idle  out  1  no chunks pending (holding register empty).
- chunks_left  out  clog2(RATIO+1)  chunks remaining in the holding register.

Behaviour:
- State: holding register hold[OUT_WIDTH*RATIO-1:0] and counter cnt (0..RATIO); chunks_left = cnt.
- States: EMPTY (cnt=0) and SHIFT (cnt>0). No other state.
- Reset (rst=1 at a rising edge): cnt <= 0. hold contents are don't-care.
- While rst=1: in_rd_en=0 and out_wr_en=0, combinationally in the same cycle.
- After reset: idle=1, chunks_left=0, in_rd_en=0, out_wr_en=0.
- out_wr_en = ~rst & (cnt!=0) & ~out_full. Combinational; out_full must come from a registered flag.
- out_din:
  - MSB_FIRST=0: hold[OUT_WIDTH-1:0].
  - MSB_FIRST=1: hold[top OUT_WIDTH bits].
  - Must be stable whenever cnt!=0.
- in_rd_en = ~rst & ~in_empty & (cnt==0 | (cnt==1 & out_wr_en)). It is never asserted while in_empty=1.
- On in_rd_en: hold <= in_dout, cnt <= RATIO. This takes priority over the shift.
- On out_wr_en without in_rd_en:
  - cnt <= cnt-1.
  - hold shifts by OUT_WIDTH toward the emitting end; vacated bits are don't-care.
- Neither strobe active: hold and cnt unchanged.
- Latency: word present (in_empty=0) in cycle N with cnt=0 → in_rd_en in N → first out_wr_en in N+1.
- Throughput: with upstream never empty and out_full=0, out_wr_en stays high continuously. in_rd_en pulses once every RATIO cycles, in the cycle the last chunk is written.
- Backpressure: out_full=1 holds out_wr_en=0 with out_din and cnt frozen for any number of cycles. No chunk is dropped or duplicated.
- Last chunk under backpressure (cnt=1, out_full=1): in_rd_en=0; the next word is not popped until the last chunk is written.
- Upstream empty while cnt=0: idle=1, no strobes. A word arriving later starts with the latency above.
- idle = (cnt==0), combinational from the register.
- Reset mid-word: remaining chunks are discarded and nothing is popped from upstream during rst. The next word after rst deasserts starts at chunk 0.
- Ordering: chunks of word k are all written before any chunk of word k+1. Each upstream word yields exactly RATIO writes.

Test Plan:
- Single word, OUT_WIDTH=8, RATIO=4, MSB_FIRST=0, in_dout=0x44332211 → one in_rd_en pulse, then out_din 0x11,0x22,0x33,0x44 on 4 consecutive out_wr_en cycles, then idle=1, chunks_left=0.
- Back-to-back words 0x44332211, 0x88776655 preloaded, out_full=0 → 8 consecutive writes 0x11..0x88. in_rd_en high in cycle 0 and cycle 4 only, with no bubble between 0x44 and 0x55.
- Backpressure: out_full=1 for 3 cycles when chunks_left=3 → out_wr_en=0 with out_din=0x22 held for 3 cycles, then 0x22,0x33,0x44. Exactly 4 writes total.
- Last chunk stalled: out_full=1 while chunks_left=1 with next word waiting → in_rd_en=0 throughout. The pop happens in the cycle 0x44 is written, and 0x55 follows immediately.
- Reset mid-word after 0x11,0x22 written, then rst=0 with 0x88776655 available → no further 0x33/0x44. The next outputs are 0x55,0x66,0x77,0x88, and chunks_left=0 during reset.
- MSB_FIRST=1, in_dout=0x44332211 → out_din 0x44,0x33,0x22,0x11. With in_empty held 1, idle stays 1 and in_rd_en and out_wr_en never assert.
